mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_addr_decode.sv | 27 ++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default address map for the two-port memory arbiter.
package mem_arbiter_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Which port owns the transaction in flight.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    // Default address map: 2K words of RAM followed by the LED and button registers.
    localparam int DEF_RAM_WORDS = 2048;
    localparam int DEF_LED_ADDR  = 2048;
    localparam int DEF_BUT_ADDR  = 2049;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int RAM_ADDR_W = 11;

endpackage

// File: rtl/mem_arbiter_addr_decode.sv
// Address decoder: classifies a 16-bit bus address as RAM, LED register or button input.
module mem_addr_decode
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_WORDS = DEF_RAM_WORDS,
    parameter int LED_ADDR  = DEF_LED_ADDR,
    parameter int BUT_ADDR  = DEF_BUT_ADDR
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              is_ram,
    output logic              is_led,
    output logic              is_but
);

    // One extra bit so RAM_WORDS = 65536 still compares correctly.
    localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);
    localparam logic [ADDR_W-1:0] LED_A     = ADDR_W'(LED_ADDR);
    localparam logic [ADDR_W-1:0] BUT_A     = ADDR_W'(BUT_ADDR);

    // RAM takes precedence so an overlapping register address still hits RAM.
    always_comb begin
        is_ram = ({1'b0, addr} < RAM_LIMIT);
        is_led = !is_ram && (addr == LED_A);
        is_but = !is_ram && !is_led && (addr == BUT_A);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a synchronous RAM, an LED
// register and a synchronized button input. Each transaction runs
// IDLE -> ISSUE -> RESP; the owner's ack pulses in RESP.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// contention; otherwise the CPU port has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_WORDS = DEF_RAM_WORDS,
    parameter int LED_ADDR  = DEF_LED_ADDR,
    parameter int BUT_ADDR  = DEF_BUT_ADDR
) (
    input  logic                  CLK_100MHz,
    input  logic                  RST_N,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_dataW,
    output logic                  ram_load,
    input  logic [DATA_W-1:0]     ram_dataR,
    output logic [DATA_W-1:0]     led,
    input  logic [DATA_W-1:0]     but
);

    state_t              state_reg, state_next;
    owner_t              owner_reg;
    owner_t              win_next;
    logic                any_req;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   led_reg;
    logic [DATA_W-1:0]   but_meta_reg, but_sync_reg;
    logic [DATA_W-1:0]   cpu_rdata_reg, dbg_rdata_reg;
    logic [DATA_W-1:0]   rd_mux;
    logic                is_ram, is_led, is_but;
    logic                resp_cpu, resp_dbg;

    assign any_req = cpu_req | dbg_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Last contention winner; starts at dbg so the CPU wins the first contention.
    owner_t rr_last_reg;

    // Winner selection: the port that lost the previous contention wins this one.
    always_comb begin
        win_next = OWN_CPU;
        if (cpu_req && dbg_req)
            win_next = (rr_last_reg == OWN_CPU) ? OWN_DBG : OWN_CPU;
        else if (dbg_req)
            win_next = OWN_DBG;
    end

    // Only contended grants move the pointer, so an uncontested grant to the
    // loser does not hand it priority again on the next contention.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N)
            rr_last_reg <= OWN_DBG;
        else if (state_reg == IDLE && cpu_req && dbg_req)
            rr_last_reg <= win_next;
    end
`else
    // Winner selection: fixed CPU priority.
    always_comb begin
        win_next = cpu_req ? OWN_CPU : OWN_DBG;
    end
`endif

    // Address decode of the latched transaction address.
    mem_addr_decode #(
        .RAM_WORDS (RAM_WORDS),
        .LED_ADDR  (LED_ADDR),
        .BUT_ADDR  (BUT_ADDR)
    ) u_decode (
        .addr   (addr_reg),
        .is_ram (is_ram),
        .is_led (is_led),
        .is_but (is_but)
    );

    // State register.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: every transaction takes exactly three cycles.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the winning port's operands when a transaction starts.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            owner_reg <= OWN_CPU;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (state_reg == IDLE && any_req) begin
            owner_reg <= win_next;
            we_reg    <= (win_next == OWN_DBG) ? dbg_we    : cpu_we;
            addr_reg  <= (win_next == OWN_DBG) ? dbg_addr  : cpu_addr;
            wdata_reg <= (win_next == OWN_DBG) ? dbg_wdata : cpu_wdata;
        end
    end

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            but_meta_reg <= '0;
            but_sync_reg <= '0;
        end else begin
            but_meta_reg <= but;
            but_sync_reg <= but_meta_reg;
        end
    end

    // LED register updates on the edge that ends RESP of an LED write.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N)
            led_reg <= '0;
        else if (state_reg == RESP && we_reg && is_led)
            led_reg <= wdata_reg;
    end

    // Read-data mux; RAM data is valid in RESP, one cycle after the address.
    always_comb begin
        rd_mux = '0;
        if (is_ram)
            rd_mux = ram_dataR;
        else if (is_led)
            rd_mux = led_reg;
        else if (is_but)
            rd_mux = but_sync_reg;
    end

    assign resp_cpu = (state_reg == RESP) && (owner_reg == OWN_CPU);
    assign resp_dbg = (state_reg == RESP) && (owner_reg == OWN_DBG);

    // Hold the last returned word per port so rdata is stable between acks.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            if (resp_cpu) cpu_rdata_reg <= rd_mux;
            if (resp_dbg) dbg_rdata_reg <= rd_mux;
        end
    end

    assign cpu_ack   = resp_cpu;
    assign dbg_ack   = resp_dbg;
    assign cpu_rdata = resp_cpu ? rd_mux : cpu_rdata_reg;
    assign dbg_rdata = resp_dbg ? rd_mux : dbg_rdata_reg;

    // RAM side: address and data come straight from the latched operands so they
    // fall to zero the moment reset asserts; the write strobe lives only in ISSUE.
    assign ram_addr  = addr_reg[RAM_ADDR_W-1:0];
    assign ram_dataW = wdata_reg;
    assign ram_load  = (state_reg == ISSUE) && we_reg && is_ram;
    assign led       = led_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks, a negedge
// monitor pops and compares port, cycle and read data. Includes a RAM model.
module tb_mem_arbiter;

    logic        CLK_100MHz = 1'b0;
    logic        RST_N;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_ack, dbg_ack, ram_load;
    logic [15:0] cpu_rdata, dbg_rdata, ram_dataW, ram_dataR, led, but;
    logic [10:0] ram_addr;

    mem_arbiter dut (
        .CLK_100MHz (CLK_100MHz),
        .RST_N      (RST_N),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .ram_addr   (ram_addr),
        .ram_dataW  (ram_dataW),
        .ram_load   (ram_load),
        .ram_dataR  (ram_dataR),
        .led        (led),
        .but        (but)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    typedef struct {
        logic        port;     // 0 = cpu, 1 = dbg
        logic        chk;      // compare read data
        logic [15:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          load_cnt = 0;
    logic [15:0] mem [0:2047];

    // Synchronous RAM model: write on ram_load, read data one cycle later.
    initial for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    always @(posedge CLK_100MHz) begin
        if (ram_load) mem[ram_addr] <= ram_dataW;
        ram_dataR <= mem[ram_addr];
    end

    always @(posedge CLK_100MHz) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge CLK_100MHz) begin
        exp_t e;
        if (ram_load) load_cnt++;
        if (cpu_ack && dbg_ack) begin
            tests++; fails++;
            $display("FAIL both_acks: got cpu_ack=1 dbg_ack=1, expected one at most (cycle %0d)", cyc);
        end else if (cpu_ack || dbg_ack) begin
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ack: got ack on %s, expected none (cycle %0d)",
                         dbg_ack ? "dbg" : "cpu", cyc);
            end else begin
                e = sb_q.pop_front();
                check("ack_port", int'(dbg_ack), int'(e.port));
                check("ack_cycle", cyc, e.ack_cyc);
                if (e.chk) check("ack_rdata", int'(dbg_ack ? dbg_rdata : cpu_rdata), int'(e.data));
                $display("[TB] ack %s rdata=0x%04h cycle=%0d", dbg_ack ? "dbg" : "cpu",
                         dbg_ack ? dbg_rdata : cpu_rdata, cyc);
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // Single transaction; call at posedge+1 with the arbiter idle.
    task automatic txn(input logic port, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic chk, input logic [15:0] exp_data);
        exp_t e;
        bit   got = 0;
        e.port = port; e.chk = chk; e.data = exp_data; e.ack_cyc = cyc + 2;
        sb_q.push_back(e);
        drive(port, 1'b1, we, addr, wdata);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_100MHz);
            if (port ? dbg_ack : cpu_ack) begin got = 1; break; end
        end
        @(posedge CLK_100MHz); #1;
        drive(port, 1'b0, 1'b0, 16'h0000, 16'h0000);
        if (!got) begin
            tests++; fails++;
            $display("FAIL txn_timeout: got no ack for addr 0x%04h, expected ack", addr);
        end
    endtask

    // Both ports read in the same cycle: cpu reads 7, dbg reads 8.
    task automatic contend(input logic first_port);
        exp_t e1, e2;
        bit   c_done = 0, d_done = 0;
        e1.port = first_port;  e1.chk = 1; e1.ack_cyc = cyc + 2;
        e2.port = !first_port; e2.chk = 1; e2.ack_cyc = cyc + 5;
        e1.data = first_port ? 16'h0808 : 16'h0707;
        e2.data = first_port ? 16'h0707 : 16'h0808;
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        drive(1'b0, 1'b1, 1'b0, 16'd7, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'd8, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_100MHz);
            if (cpu_ack) c_done = 1;
            if (dbg_ack) d_done = 1;
            @(posedge CLK_100MHz); #1;
            if (c_done) cpu_req = 1'b0;
            if (d_done) dbg_req = 1'b0;
            if (c_done && d_done) break;
        end
        if (!(c_done && d_done)) begin
            tests++; fails++;
            $display("FAIL contend_timeout: got cpu=%0d dbg=%0d acks, expected both", c_done, d_done);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        RST_N = 1'b0; but = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge CLK_100MHz);
        #1;
        check("rst_cpu_ack", int'(cpu_ack), 0);
        check("rst_dbg_ack", int'(dbg_ack), 0);
        check("rst_ram_load", int'(ram_load), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_led", int'(led), 0);
        check("rst_cpu_rdata", int'(cpu_rdata), 0);
        check("rst_dbg_rdata", int'(dbg_rdata), 0);
        RST_N = 1'b1;
        @(posedge CLK_100MHz); #1;

        // CPU write then read back address 5.
        l0 = load_cnt;
        txn(1'b0, 1'b1, 16'd5, 16'h1234, 1'b0, 16'h0000);
        check("wr5_load_cycles", load_cnt - l0, 1);
        txn(1'b0, 1'b0, 16'd5, 16'h0000, 1'b1, 16'h1234);
        repeat (2) @(posedge CLK_100MHz);
        #1;
        check("cpu_rdata_hold", int'(cpu_rdata), 16'h1234);

        // Preload distinct words at 7 and 8 from each port.
        txn(1'b1, 1'b1, 16'd7, 16'h0707, 1'b0, 16'h0000);
        txn(1'b0, 1'b1, 16'd8, 16'h0808, 1'b0, 16'h0000);
        txn(1'b1, 1'b0, 16'd8, 16'h0000, 1'b1, 16'h0808);

        // Two contentions.
        contend(1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        contend(1'b1);
`else
        contend(1'b0);
`endif

        // LED register write / read from the debug port.
        l0 = load_cnt;
        txn(1'b1, 1'b1, 16'd2048, 16'h00FF, 1'b0, 16'h0000);
        check("led_wr_no_load", load_cnt - l0, 0);
        check("led_value", int'(led), 16'h00FF);
        txn(1'b1, 1'b0, 16'd2048, 16'h0000, 1'b1, 16'h00FF);

        // Button input through the synchronizer; writes there are dropped.
        but = 16'h0003;
        repeat (3) @(posedge CLK_100MHz);
        #1;
        txn(1'b0, 1'b0, 16'd2049, 16'h0000, 1'b1, 16'h0003);
        l0 = load_cnt;
        txn(1'b0, 1'b1, 16'd2049, 16'hAAAA, 1'b0, 16'h0000);
        check("but_wr_no_load", load_cnt - l0, 0);
        check("but_wr_led_same", int'(led), 16'h00FF);
        txn(1'b1, 1'b0, 16'd2049, 16'h0000, 1'b1, 16'h0003);

        // Unmapped address: reads zero, writes touch nothing (0x6000 aliases RAM word 0).
        txn(1'b0, 1'b0, 16'h6000, 16'h0000, 1'b1, 16'h0000);
        l0 = load_cnt;
        txn(1'b0, 1'b1, 16'h6000, 16'h5555, 1'b0, 16'h0000);
        check("unmapped_wr_no_load", load_cnt - l0, 0);
        txn(1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 16'h0000);

        // Reset during ISSUE of a write to address 9.
        l0 = load_cnt;
        drive(1'b0, 1'b1, 1'b1, 16'd9, 16'hBEEF);
        @(posedge CLK_100MHz); #1;
        check("issue_ram_load", int'(ram_load), 1);
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid_ram_load", int'(ram_load), 0);
        check("rst_mid_cpu_ack", int'(cpu_ack), 0);
        check("rst_mid_ram_addr", int'(ram_addr), 0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(posedge CLK_100MHz);
        #1;
        RST_N = 1'b1;
        txn(1'b0, 1'b0, 16'd9, 16'h0000, 1'b1, 16'h0000);
        check("rst_no_ram_write", load_cnt - l0, 0);
        check("rst_mem9_model", int'(mem[9]), 0);

        repeat (5) @(posedge CLK_100MHz);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
